// File: rtl/set_input_ctrl.sv
// ============================================================================
// set_input_ctrl
// ----------------------------------------------------------------------------
// Front-end conditioning for the digital clock's five manual buttons.
// Each raw button is passed through a 2-flop synchronizer and a debouncer. A
// 0->1 transition of the debounced level is a press event. Press events drive
// a RUN / SET_TIME / SET_ALARM mode machine, the alarm-enable toggle, and two
// independent advance channels (minutes, hours). Each advance channel emits
// a single-cycle pulse on a press and auto-repeats while the button is held.
//
// Parameters:
//   DB_CYCLES  consecutive synchronized cycles a new level must persist (>=1)
//   RPT_DELAY  cycles from the first advance pulse to the first repeat (>=2)
//   RPT_RATE   cycles between repeat pulses (>=2, and <= RPT_DELAY; a larger
//              value degrades to a repeat period of RPT_DELAY)
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   btn_timeset    in   raw asynchronous button, active high
//   btn_alarmset   in   raw asynchronous button, active high
//   btn_minadv     in   raw asynchronous button, active high
//   btn_hrsadv     in   raw asynchronous button, active high
//   btn_alarmon    in   raw asynchronous button, active high
//   Timeset        out  high while the mode is SET_TIME
//   Alarmset       out  high while the mode is SET_ALARM
//   Minadv         out  one-cycle minute-advance pulse
//   Hrsadv         out  one-cycle hour-advance pulse
//   Alarmon        out  alarm-enable level, toggled by each alarmon press
//
// All outputs come straight from flops; no combinational path exists from
// any btn_* input to an output.
// ============================================================================
module set_input_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int RPT_DELAY = 8,
    parameter int RPT_RATE  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_timeset,
    input  logic btn_alarmset,
    input  logic btn_minadv,
    input  logic btn_hrsadv,
    input  logic btn_alarmon,
    output logic Timeset,
    output logic Alarmset,
    output logic Minadv,
    output logic Hrsadv,
    output logic Alarmon
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int NBTN = 5;
    localparam int B_TS = 0;
    localparam int B_AS = 1;
    localparam int B_MN = 2;
    localparam int B_HR = 3;
    localparam int B_AO = 4;

    // Debounce counter: counts up to DB_CYCLES-1, then accepts the new level.
    localparam int             CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  DB_ZERO = {CW{1'b0}};

    // Hold counter: the pulse fires when the counter reaches RPT_DELAY-1.
    // After the first pulse it restarts at RPT_DELAY-RPT_RATE so that later
    // pulses come every RPT_RATE cycles with the same compare value.
    localparam int             HW          = $clog2(RPT_DELAY + 1);
    localparam int             RELOAD_INT  = (RPT_RATE <= RPT_DELAY) ?
                                             (RPT_DELAY - RPT_RATE) : 32'sd0;
    localparam logic [HW-1:0]  HCNT_LAST   = HW'(RPT_DELAY - 1);
    localparam logic [HW-1:0]  HCNT_RELOAD = HW'(RELOAD_INT);
    localparam logic [HW-1:0]  HCNT_ZERO   = {HW{1'b0}};

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [NBTN-1:0] raw_s;        // raw buttons, bit order = B_* indices
    logic [NBTN-1:0] press_s;      // one-cycle press events
    logic [1:0]      adv_level_s;  // debounced level of minadv (0) / hrsadv (1)
    logic [1:0]      adv_press_s;  // press event of minadv (0) / hrsadv (1)
    logic [1:0]      adv_pulse_s;  // registered advance pulses

    mode_t           mode_r;
    mode_t           mode_nxt_s;
    logic            in_set_s;
    logic            mode_change_s;

    assign raw_s = {btn_alarmon, btn_hrsadv, btn_minadv, btn_alarmset, btn_timeset};

    // ------------------------------------------------------------------------
    // Per-button synchronizer, debouncer and press detector
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NBTN; i++) begin : g_db
        logic          sync1_r;
        logic          sync2_r;
        logic          stable_r;
        logic          stable_q_r;
        logic [CW-1:0] cnt_r;

        // Synchronize the raw input and accept a new level only after it has
        // differed from the accepted level for DB_CYCLES consecutive cycles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_r    <= 1'b0;
                sync2_r    <= 1'b0;
                stable_r   <= 1'b0;
                stable_q_r <= 1'b0;
                cnt_r      <= DB_ZERO;
            end else begin
                sync1_r    <= raw_s[i];
                sync2_r    <= sync1_r;
                stable_q_r <= stable_r;
                if (sync2_r == stable_r) begin
                    cnt_r <= DB_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    stable_r <= sync2_r;
                    cnt_r    <= DB_ZERO;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end
        end

        // Releases produce no event; only the rising edge of the level counts.
        assign press_s[i] = stable_r & ~stable_q_r;

        if ((i == B_MN) || (i == B_HR)) begin : g_adv_tap
            assign adv_level_s[i - B_MN] = stable_r;
        end
    end

    assign adv_press_s = press_s[B_HR:B_MN];

    // ------------------------------------------------------------------------
    // Mode machine
    // ------------------------------------------------------------------------
    // Next-mode decode; a timeset press outranks a simultaneous alarmset press.
    always_comb begin
        mode_nxt_s = mode_r;
        case (mode_r)
            MODE_RUN: begin
                if (press_s[B_TS]) begin
                    mode_nxt_s = MODE_SET_TIME;
                end else if (press_s[B_AS]) begin
                    mode_nxt_s = MODE_SET_ALARM;
                end else begin
                    mode_nxt_s = MODE_RUN;
                end
            end
            MODE_SET_TIME: begin
                if (press_s[B_TS]) begin
                    mode_nxt_s = MODE_RUN;
                end else if (press_s[B_AS]) begin
                    mode_nxt_s = MODE_SET_ALARM;
                end else begin
                    mode_nxt_s = MODE_SET_TIME;
                end
            end
            MODE_SET_ALARM: begin
                if (press_s[B_TS]) begin
                    mode_nxt_s = MODE_SET_TIME;
                end else if (press_s[B_AS]) begin
                    mode_nxt_s = MODE_RUN;
                end else begin
                    mode_nxt_s = MODE_SET_ALARM;
                end
            end
            default: begin
                mode_nxt_s = MODE_RUN;
            end
        endcase
    end

    assign in_set_s      = (mode_r == MODE_SET_TIME) || (mode_r == MODE_SET_ALARM);
    assign mode_change_s = (mode_nxt_s != mode_r);

    // Mode register with registered mode levels and the alarm-enable toggle.
    // The levels are decoded from the next mode so they change on the same
    // edge as the mode itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= MODE_RUN;
            Timeset  <= 1'b0;
            Alarmset <= 1'b0;
            Alarmon  <= 1'b0;
        end else begin
            mode_r   <= mode_nxt_s;
            Timeset  <= (mode_nxt_s == MODE_SET_TIME);
            Alarmset <= (mode_nxt_s == MODE_SET_ALARM);
            if (press_s[B_AO]) begin
                Alarmon <= ~Alarmon;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Advance channels (0 = minutes, 1 = hours), identical and independent
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < 2; j++) begin : g_adv
        logic          armed_r;
        logic          pulse_r;
        logic [HW-1:0] hcnt_r;

        // Press in a setting mode emits the first pulse and arms repeat.
        // Any mode change or a debounced release disarms; only a new press
        // can re-arm, so a button held across a mode change stays silent.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                armed_r <= 1'b0;
                pulse_r <= 1'b0;
                hcnt_r  <= HCNT_ZERO;
            end else begin
                pulse_r <= 1'b0;
                if (adv_press_s[j] && in_set_s) begin
                    pulse_r <= 1'b1;
                    armed_r <= ~mode_change_s;
                    hcnt_r  <= HCNT_ZERO;
                end else if (mode_change_s || !adv_level_s[j]) begin
                    armed_r <= 1'b0;
                    hcnt_r  <= HCNT_ZERO;
                end else if (armed_r) begin
                    if (hcnt_r == HCNT_LAST) begin
                        pulse_r <= 1'b1;
                        hcnt_r  <= HCNT_RELOAD;
                    end else begin
                        hcnt_r <= hcnt_r + HW'(1);
                    end
                end else begin
                    hcnt_r <= HCNT_ZERO;
                end
            end
        end

        assign adv_pulse_s[j] = pulse_r;
    end

    assign Minadv = adv_pulse_s[0];
    assign Hrsadv = adv_pulse_s[1];

endmodule

// File: doc/set_input_ctrl.md
# set_input_ctrl

Front-end conditioning for the digital clock's five manual buttons. It synchronizes and debounces the raw switch inputs and runs a RUN / SET_TIME / SET_ALARM mode state machine. It produces the level signals `Timeset`, `Alarmset` and `Alarmon`, plus clean single-cycle `Minadv` / `Hrsadv` advance pulses with hold-to-auto-repeat. It drives the clock top level's button inputs, which it otherwise receives directly from switches.

## Interface

Parameters:
- `DB_CYCLES`, default 4: consecutive synchronized cycles a new level must persist before it is accepted (≥1).
- `RPT_DELAY`, default 8: cycles from the first advance pulse to the first repeat pulse (≥2).
- `RPT_RATE`, default 2: cycles between repeat pulses (≥2, so every pulse is followed by at least one low cycle).

Ports:
- `clk` in 1: single clock; all state is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `btn_timeset`, `btn_alarmset`, `btn_minadv`, `btn_hrsadv`, `btn_alarmon` in 1 each: raw, asynchronous, active-high buttons.
- `Timeset` out 1: high while the mode is SET_TIME.
- `Alarmset` out 1: high while the mode is SET_ALARM.
- `Minadv` out 1: one-cycle minute-advance pulse.
- `Hrsadv` out 1: one-cycle hour-advance pulse.
- `Alarmon` out 1: alarm-enable toggle level.

## Operation

**Per-button path (five identical instances)**
- 2-flop synchronizer produces `s`.
- Debouncer holds a `stable` level and a counter `cnt` sized `$clog2(DB_CYCLES+1)`.
- At each edge where `s == stable`: `cnt <= 0`.
- At each edge where `s != stable`:
  - if `cnt == DB_CYCLES-1`, then `stable <= s` and `cnt <= 0`;
  - otherwise `cnt <= cnt+1`.
- A press event is a `stable` 0→1 transition, detected against a registered copy of `stable`. Releases generate no event.

**Mode FSM (states RUN, SET_TIME, SET_ALARM)**
- RUN: timeset press → SET_TIME; alarmset press → SET_ALARM.
- SET_TIME: timeset press → RUN; alarmset press → SET_ALARM.
- SET_ALARM: alarmset press → RUN; timeset press → SET_TIME.
- If timeset and alarmset press events occur in the same cycle, timeset wins and the alarmset event is discarded.

**Advance (min and hrs independent, identical logic)**
- The hold counter is sized `$clog2(RPT_DELAY+1)`.
- A press while in SET_TIME or SET_ALARM emits a pulse P and arms repeat.
- While armed and `stable` stays high, pulses occur at P+RPT_DELAY and then every RPT_RATE cycles.
- Disarm on any of: debounced release, any mode change, or `rst`.
- A re-arm requires a new press event. Holding the button across a mode change never restarts repeat.
- A press in RUN emits nothing and does not arm.
- Min and hrs may pulse in the same cycle.

**Alarmon**
- Toggles on each alarmon press event, in any mode.

**Reset**
- All synchronizers, `stable`, counters and outputs go to 0, and the mode goes to RUN.
- A button still held when `rst` deasserts is re-debounced from `stable = 0`, so it counts as a fresh press.

## Timing

- Take edge k as the first edge that samples a new raw level.
- `s` changes after edge k+1.
- `stable` updates at edge k+1+DB_CYCLES.
- Press-driven outputs (mode levels, P pulse, `Alarmon` toggle) change at edge k+2+DB_CYCLES. With defaults, that is 6 cycles after the first sample.
- Repeat pulses at edge e require `stable` high in cycle e-1.
- All outputs are registered; there are no combinational paths from the `btn_*` inputs to the outputs.

## Test plan

Defaults are used throughout (DB_CYCLES=4, RPT_DELAY=8, RPT_RATE=2).

1. **Reset and glitch rejection:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately. In SET_TIME, hold raw `btn_minadv` high for 3 sampled cycles → no `Minadv` pulse and no internal state change.
2. **Mode toggling:** `btn_timeset` sampled high at edges 0–9 → `Timeset` high from edge 6. Re-press → `Timeset` low. Then press alarmset while in SET_TIME → `Alarmset` high and `Timeset` low in the same cycle.
3. **Auto-repeat:** in SET_TIME, `btn_minadv` sampled high at edges 0–19 → `Minadv` high for exactly one cycle after edges 6, 14, 16, 18, 20, 22 and 24 (7 pulses), and none after that.
4. **RUN-mode advance and Alarmon:** in RUN, press minadv and hrsadv → no pulses. Press alarmon twice → `Alarmon` goes 0→1→0, each change 6 cycles after its press sample.
5. **Simultaneous and mid-hold events:**
   - Timeset and alarmset sampled high in the same cycle from RUN → SET_TIME.
   - Minadv held in SET_TIME, then timeset pressed (→ RUN) → repeats stop at once.
   - Alarmset then pressed while minadv is still held (→ SET_ALARM) → no new pulse until minadv is released and re-pressed.
6. **Reset mid-hold:** pulse `rst` during a minadv hold in SET_TIME → mode returns to RUN and no further `Minadv` pulses. Re-enter SET_TIME while minadv is still held → no pulse until a new press.
